// File: rtl/divu_seq_pkg.sv
// Shared definitions for the execute-stage ALU/divider slice: function codes,
// operand width and the divider FSM state encoding.
package divu_seq_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;

    localparam logic [5:0] AND  = 6'b100100;
    localparam logic [5:0] OR   = 6'b100101;
    localparam logic [5:0] ADD  = 6'b100000;
    localparam logic [5:0] SUB  = 6'b100010;
    localparam logic [5:0] SLT  = 6'b101010;
    localparam logic [5:0] DIVU = 6'b011011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/divu_seq_if.sv
// Request/result bundle between the execute-stage control path (master)
// and the sequential divider (slave).
interface divu_seq_if
    import divu_seq_pkg::*;
();

    logic             start;
    logic [5:0]       Signal;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             divZero;

    modport master (
        output start, Signal, dataA, dataB,
        input  busy, done, quotient, remainder, divZero
    );

    modport slave (
        input  start, Signal, dataA, dataB,
        output busy, done, quotient, remainder, divZero
    );

endinterface

// File: rtl/divu_seq_div_step.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder, trial-subtract the divisor, keep or restore.
module divu_seq_div_step
    import divu_seq_pkg::*;
(
    input  logic [WIDTH:0]   i_r,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH:0]   o_r,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_diff;
    logic             w_neg;

    // R never reaches D, so the shifted value is below 2*D and the low 33 bits
    // of the difference equal T; one extra bit keeps all of R in the datapath.
    assign w_shift = {i_r, i_q[WIDTH-1]};
    assign w_diff  = w_shift - {2'b00, i_d};
    assign w_neg   = w_diff[WIDTH+1];

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
        o_r = w_diff[WIDTH:0];
        o_q = {i_q[WIDTH-2:0], 1'b1};
        if (w_neg) begin
            o_r = w_shift[WIDTH:0];
            o_q = {i_q[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/divu_seq.sv
// Sequential 32-bit unsigned divider for the MIPS DIVU function: 32 restoring
// steps after acceptance, then a one-cycle done with quotient (LO) / remainder (HI).
module divu_seq
    import divu_seq_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    divu_seq_if.slave bus
);

    state_e           r_state;
    state_e           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_r;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_zero;

    logic [WIDTH:0]   w_r_next;
    logic [WIDTH-1:0] w_q_next;
    logic             w_accept;
    logic             w_run;
    logic             w_last;

    divu_seq_div_step u_step (
        .i_r (r_r),
        .i_q (r_q),
        .i_d (r_d),
        .o_r (w_r_next),
        .o_q (w_q_next)
    );

    // A request in RUN is dropped; IDLE and DONE may both accept.
    assign w_accept = bus.start && (bus.Signal == DIVU) && (r_state != RUN);
    assign w_run    = (r_state == RUN);
    assign w_last   = w_run && (r_cnt == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_state_next = RUN;
            RUN:     if (r_cnt == '0) w_state_next = DONE;
            DONE:    w_state_next = w_accept ? RUN : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_r   <= '0;
            r_q   <= '0;
            r_d   <= '0;
        end else if (w_accept) begin
            r_cnt <= CNT_W'(WIDTH - 1);
            r_r   <= '0;
            r_q   <= bus.dataA;
            r_d   <= bus.dataB;
        end else if (w_run) begin
            r_cnt <= r_cnt - 1'b1;
            r_r   <= w_r_next;
            r_q   <= w_q_next;
        end
    end

    // Results are loaded from the final step's outputs on the edge entering DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
        end else if (w_accept) begin
            r_div_zero  <= 1'b0;
        end else if (w_last) begin
            r_quotient  <= w_q_next;
            r_remainder <= w_r_next[WIDTH-1:0];
            r_div_zero  <= (r_d == '0);
        end
    end

    assign bus.busy      = w_run;
    assign bus.done      = (r_state == DONE);
    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;
    assign bus.divZero   = r_div_zero;

endmodule

// File: tb/tb_divu_seq.sv
// Scoreboard bench for divu_seq: expected results queued at request time,
// popped and compared when done pulses.
module tb_divu_seq;
    import divu_seq_pkg::*;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int unsigned done_cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int unsigned cyc;
    int unsigned n_vec;
    int unsigned n_miss;
    int unsigned n_done;
    exp_t        sb[$];

    divu_seq_if bus ();

    divu_seq dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int unsigned n);
        exp_t e;
        e.dz = (b == 32'd0);
        e.q  = e.dz ? 32'hFFFF_FFFF : a / b;
        e.r  = e.dz ? a : a % b;
        e.done_cyc = n + 33;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            n_done++;
            if (sb.size() == 0) begin
                check("spurious_done", bus.done, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", bus.quotient, e.q);
                check("remainder", bus.remainder, e.r);
                check("divZero", bus.divZero, e.dz);
                check("done_latency", cyc, e.done_cyc);
                check("busy_at_done", bus.busy, 1'b0);
            end
        end
    end

    // Caller sits on a negedge; the request is seen by the following posedge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [5:0] sig,
                         input bit accept, input logic exp_busy);
        bus.start  = 1'b1;
        bus.Signal = sig;
        bus.dataA  = a;
        bus.dataB  = b;
        if (accept) sb.push_back(model(a, b, cyc));
        @(negedge clk);
        bus.start  = 1'b0;
        bus.Signal = 6'd0;
        check("busy_after_req", bus.busy, exp_busy);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        check("drain", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, bus.busy, 1'b0);
        check({tag, "_done"}, bus.done, 1'b0);
        check({tag, "_quotient"}, bus.quotient, 32'd0);
        check({tag, "_remainder"}, bus.remainder, 32'd0);
        check({tag, "_divZero"}, bus.divZero, 1'b0);
    endtask

    initial begin
        int unsigned done_before;
        cyc = 0; n_vec = 0; n_miss = 0; n_done = 0;
        bus.start = 1'b0; bus.Signal = 6'd0; bus.dataA = '0; bus.dataB = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        #3 rst_n = 1'b1;
        @(negedge clk);

        issue(32'd100, 32'd7, DIVU, 1'b1, 1'b1);
        drain();
        check("hold_quotient", bus.quotient, 32'd14);
        check("hold_remainder", bus.remainder, 32'd2);

        issue(32'hFFFF_FFFF, 32'd1, DIVU, 1'b1, 1'b1);
        drain();
        issue(32'd5, 32'hFFFF_FFFF, DIVU, 1'b1, 1'b1);
        drain();

        issue(32'd1234, 32'd0, DIVU, 1'b1, 1'b1);
        drain();
        check("dz_hold_flag", bus.divZero, 1'b1);
        check("dz_hold_remainder", bus.remainder, 32'd1234);

        // A second request mid-RUN must not disturb the division in flight.
        done_before = n_done;
        issue(32'd100, 32'd7, DIVU, 1'b1, 1'b1);
        repeat (9) @(negedge clk);
        issue(32'd50, 32'd5, DIVU, 1'b0, 1'b1);
        drain();
        repeat (30) @(negedge clk);
        check("single_done", n_done - done_before, 1);

        issue(32'd8, 32'd2, ADD, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("ignored_busy", bus.busy, 1'b0);

        // Back-to-back: the second request lands in the DONE cycle of the first.
        issue(32'd9, 32'd2, DIVU, 1'b1, 1'b1);
        for (int i = 0; i < 60 && !bus.done; i++) @(negedge clk);
        check("b2b_first_done", bus.done, 1'b1);
        issue(32'd20, 32'd6, DIVU, 1'b1, 1'b1);
        drain();

        done_before = n_done;
        issue(32'd100, 32'd7, DIVU, 1'b1, 1'b1);
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        sb.delete();
        #1 check_zero_outputs("midrun_reset");
        repeat (40) @(negedge clk);
        check("no_done_after_reset", n_done - done_before, 0);
        #3 rst_n = 1'b1;
        @(negedge clk);
        issue(32'd81, 32'd9, DIVU, 1'b1, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
